// File: rtl/led_blink_scheduler_pkg.sv
// Shared definitions for the LED blink scheduler: FSM encoding, timebase
// divider computation/legality and counter width sizing.
package led_blink_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } blink_state_e;

  function automatic int calc_div(input int clk_freq_hz, input int tick_hz);
    return (tick_hz > 0) ? clk_freq_hz / tick_hz : 1;
  endfunction

  function automatic bit div_legal(input int clk_freq_hz, input int tick_hz);
    return (tick_hz > 0) && (clk_freq_hz >= tick_hz) && (clk_freq_hz % tick_hz == 0);
  endfunction

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/led_blink_scheduler_prescaler.sv
// Restartable clock-to-tick prescaler: counts 0..div-1, tick while at div-1.
module blink_tick_prescaler
  import led_blink_scheduler_pkg::*;
#(
  parameter int div = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = cnt_w(div - 1);
  localparam logic [CW-1:0] LAST = CW'(div - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Combinational from the count only; clear feeds the register, so no loop
  // through the FSM next-state logic.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_blink_scheduler.sv
// Round-robin shared-LED blink scheduler: grants one requester at a time and
// plays its code as N on/off pulses followed by a dark gap.
module led_blink_scheduler
  import led_blink_scheduler_pkg::*;
#(
  parameter int clk_freq_hz = 16_000_000,
  parameter int tick_hz     = 1000,
  parameter int num_req     = 4,
  parameter int code_w      = 4,
  parameter int on_ticks    = 200,
  parameter int off_ticks   = 200,
  parameter int gap_ticks   = 1000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [num_req-1:0]           req_valid,
  input  logic [num_req*code_w-1:0]    req_code,
  output logic [num_req-1:0]           req_ready,
  output logic                         busy,
  output logic [$clog2(num_req)-1:0]   grant_id,
  output logic                         done,
  output logic                         led
);

  localparam int DIV = calc_div(clk_freq_hz, tick_hz);
  localparam int IDW = $clog2(num_req);
  localparam int TW  = cnt_w(max3(on_ticks, off_ticks, gap_ticks));
  localparam logic [TW-1:0] ON_LAST  = TW'(on_ticks - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(off_ticks - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(gap_ticks - 1);

  if (!div_legal(clk_freq_hz, tick_hz) || num_req < 2 || code_w < 1 ||
      on_ticks < 1 || off_ticks < 1 || gap_ticks < 1) begin : g_param_check
    $error("led_blink_scheduler: illegal parameter set");
  end

  blink_state_e      state, state_n;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    win_idx;
  logic              win_found;
  logic [code_w-1:0] code_sel;
  logic [code_w-1:0] pulses;
  logic [TW-1:0]     tcnt;
  logic [TW-1:0]     tcnt_last;
  logic              last_tick;
  logic              tick;
  logic              presc_clear;

  // Round-robin search starting at the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < num_req; k++) begin
      if (!win_found && req_valid[(int'(ptr) + k) % num_req]) begin
        win_found = 1'b1;
        win_idx   = IDW'((int'(ptr) + k) % num_req);
      end
    end
  end

  assign code_sel = req_code[win_idx*code_w +: code_w];

  always_comb begin
    tcnt_last = GAP_LAST;
    case (state)
      ST_ON:   tcnt_last = ON_LAST;
      ST_OFF:  tcnt_last = OFF_LAST;
      default: tcnt_last = GAP_LAST;
    endcase
  end

  assign last_tick = tick && (tcnt == tcnt_last);

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (win_found) state_n = (code_sel != '0) ? ST_ON : ST_GAP;
      ST_ON:   if (last_tick) state_n = ST_OFF;
      ST_OFF:  if (last_tick) state_n = (pulses != '0) ? ST_ON : ST_GAP;
      ST_GAP:  if (last_tick) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Every state entry restarts the timebase so durations are exact in clocks.
  assign presc_clear = (state_n != state) || (state == ST_IDLE);

  blink_tick_prescaler #(.div(DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (presc_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      grant_id  <= '0;
      pulses    <= '0;
      tcnt      <= '0;
      req_ready <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      led       <= 1'b0;
    end else begin
      state     <= state_n;
      req_ready <= '0;
      if (state == ST_IDLE && win_found) begin
        req_ready <= {{(num_req-1){1'b0}}, 1'b1} << win_idx;
        grant_id  <= win_idx;
        pulses    <= code_sel;
        ptr       <= (win_idx == IDW'(num_req - 1)) ? '0 : win_idx + 1'b1;
      end else if (state == ST_ON && last_tick) begin
        pulses <= pulses - 1'b1;
      end
      if (presc_clear) begin
        tcnt <= '0;
      end else if (tick) begin
        tcnt <= tcnt + 1'b1;
      end
      busy <= (state_n != ST_IDLE);
      done <= (state == ST_GAP) && (state_n == ST_IDLE);
      // LED follows the state one clock later so it rises after req_ready.
      led  <= (state == ST_ON);
    end
  end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler with an expected-grant scoreboard.
module tb_led_blink_scheduler;

  localparam int NREQ  = 4;
  localparam int CW    = 4;
  localparam int DIV   = 10;
  localparam int ON_T  = 2;
  localparam int OFF_T = 2;
  localparam int GAP_T = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*CW-1:0] req_code;
  logic [NREQ-1:0]   req_ready;
  logic              busy;
  logic [1:0]        grant_id;
  logic              done;
  logic              led;

  led_blink_scheduler #(
    .clk_freq_hz (1000),
    .tick_hz     (100),
    .num_req     (NREQ),
    .code_w      (CW),
    .on_ticks    (ON_T),
    .off_ticks   (OFF_T),
    .gap_ticks   (GAP_T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_ready (req_ready),
    .busy      (busy),
    .grant_id  (grant_id),
    .done      (done),
    .led       (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int code;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_assert  = 0;
  int   n_fail    = 0;
  int   n_grants  = 0;
  int   n_windows = 0;
  int   win_len   = 0;
  int   rises     = 0;
  int   on_run    = 0;
  logic busy_prev = 1'b0;
  logic led_prev  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic push_exp(input int id, input int code);
    exp_t e;
    e.id   = id;
    e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic wait_grants(input int n, input int lim);
    int c = 0;
    while (n_grants < n && c < lim) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk("grant_wait", 32'(n_grants >= n), 1);
  endtask

  task automatic wait_windows(input int n, input int lim);
    int c = 0;
    while (n_windows < n && c < lim) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk("window_wait", 32'(n_windows >= n), 1);
  endtask

  // Output monitor: pops the scoreboard on each acceptance, measures windows.
  initial begin
    cur.id   = 0;
    cur.code = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_led", 32'(led), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ready", 32'(req_ready), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_grant_id", 32'(grant_id), 0);
        busy_prev = 1'b0;
        led_prev  = 1'b0;
        win_len   = 0;
        rises     = 0;
        on_run    = 0;
      end else begin
        chk("done_pulse", 32'(done), 32'(busy_prev && !busy));
        if (req_ready !== '0) begin
          n_grants++;
          if (exp_q.size() == 0) begin
            chk("unexpected_ready", 32'(req_ready), 0);
          end else begin
            cur = exp_q.pop_front();
            chk("ready_onehot", 32'(req_ready), 32'(1 << cur.id));
            chk("grant_id", 32'(grant_id), 32'(cur.id));
          end
          win_len = 0;
          rises   = 0;
        end
        if (busy) win_len++;
        if (led && !led_prev) rises++;
        if (led) begin
          on_run++;
        end else if (led_prev) begin
          chk("led_on_len", 32'(on_run), 32'(ON_T * DIV));
          on_run = 0;
        end
        if (busy_prev && !busy) begin
          n_windows++;
          chk("busy_len", 32'(win_len), 32'(cur.code * (ON_T + OFF_T) * DIV + GAP_T * DIV));
          chk("led_pulses", 32'(rises), 32'(cur.code));
        end
        busy_prev = busy;
        led_prev  = led;
      end
    end
  end

  initial begin
    int g;
    int w;
    int c;
    rst_n     = 1'b0;
    req_valid = '0;
    req_code  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request: req 2, code 3.
    @(posedge clk); #1;
    req_code[2*CW +: CW] = 4'd3;
    req_valid[2] = 1'b1;
    push_exp(2, 3);
    wait_grants(1, 20);
    req_valid[2] = 1'b0;
    wait_windows(1, 300);

    // Reset to bring the pointer home, then round-robin over 0, 1, 3.
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    g = n_grants;
    w = n_windows;
    req_code[0*CW +: CW] = 4'd1;
    req_code[1*CW +: CW] = 4'd1;
    req_code[3*CW +: CW] = 4'd1;
    req_valid = 4'b1011;
    for (int i = 0; i < 2; i++) begin
      push_exp(0, 1);
      push_exp(1, 1);
      push_exp(3, 1);
    end
    wait_grants(g + 6, 600);
    req_valid = '0;
    wait_windows(w + 6, 200);

    // Code 0 on req 1: dark window only.
    g = n_grants;
    w = n_windows;
    req_code[1*CW +: CW] = 4'd0;
    req_valid[1] = 1'b1;
    push_exp(1, 0);
    wait_grants(g + 1, 20);
    req_valid[1] = 1'b0;
    wait_windows(w + 1, 100);

    // Reset mid-code while req 0 and req 2 are pending.
    g = n_grants;
    req_code[0*CW +: CW] = 4'd3;
    req_valid[0] = 1'b1;
    push_exp(0, 3);
    wait_grants(g + 1, 20);
    req_code[0*CW +: CW] = 4'd1;
    req_code[2*CW +: CW] = 4'd1;
    req_valid[2] = 1'b1;
    c = 0;
    while (rises < 2 && c < 200) begin
      @(posedge clk);
      c++;
    end
    chk("second_pulse_wait", 32'(rises), 2);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_led", 32'(led), 0);
    chk("async_reset_busy", 32'(busy), 0);
    push_exp(0, 1);
    push_exp(2, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    g = n_grants;
    w = n_windows;
    wait_grants(g + 1, 20);
    req_valid[0] = 1'b0;
    wait_grants(g + 2, 200);
    req_valid[2] = 1'b0;
    wait_windows(w + 2, 200);

    // One-cycle req 3 pulse during a busy window is never acknowledged.
    g = n_grants;
    w = n_windows;
    req_code[1*CW +: CW] = 4'd1;
    req_valid[1] = 1'b1;
    push_exp(1, 1);
    wait_grants(g + 1, 20);
    req_valid[1] = 1'b0;
    repeat (10) @(posedge clk);
    #1 req_valid[3] = 1'b1;
    @(posedge clk);
    #1 req_valid[3] = 1'b0;
    wait_windows(w + 1, 200);
    repeat (20) @(posedge clk);
    #1;
    chk("req3_ignored", 32'(n_grants), 32'(g + 1));

    // Maximum code on req 0.
    g = n_grants;
    w = n_windows;
    req_code[0*CW +: CW] = 4'd15;
    req_valid[0] = 1'b1;
    push_exp(0, 15);
    wait_grants(g + 1, 20);
    req_valid[0] = 1'b0;
    wait_windows(w + 1, 800);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/led_blink_scheduler.md
Name: led_blink_scheduler

Overview:
- Shares the single user LED between several requesters, each asking for a blink code: N on/off pulses followed by an inter-code gap.
- Built from a round-robin arbiter, a blink-sequencing FSM and a restartable tick prescaler derived from the system clock.
- Sits between SoC status sources and the board LED pin, in place of a free-running toggle divider.

Parameters:
- clk_freq_hz, 16_000_000, system clock frequency in Hz.
- tick_hz, 1000, timebase tick rate; div = clk_freq_hz/tick_hz must be an integer >= 1 (elaboration error otherwise).
- num_req, 4, number of requesters (>= 2).
- code_w, 4, width of each pulse-count code.
- on_ticks, 200, LED-on duration per pulse, in ticks (>= 1).
- off_ticks, 200, LED-off duration after each pulse, in ticks (>= 1).
- gap_ticks, 1000, extra dark time after the last pulse, in ticks (>= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  num_req  per-requester code request.
- req_code  in  num_req*code_w  packed codes; requester i uses bits [i*code_w +: code_w].
- req_ready  out  num_req  one-hot, one-cycle acceptance pulse.
- busy  out  1  high whenever the FSM is not IDLE.
- grant_id  out  $clog2(num_req)  index of the last-accepted requester.
- done  out  1  one-cycle pulse when a code completes.
- led  out  1  LED drive, active high.

Behaviour:
- Async reset (rst_n low): led=0, req_ready=0, busy=0, done=0, grant_id=0, RR pointer=0, FSM=IDLE, all counters 0. Applies immediately, including mid-code; operation resumes in IDLE on the first clk after release.
- All outputs are registered.
- FSM states: IDLE, ON, OFF, GAP.
- IDLE:
  - Arbitration happens only here.
  - Winner = first asserted req_valid searching from the RR pointer upward, wrapping.
  - In the grant cycle: req_ready[winner]=1, code and grant_id latched, pointer = (winner+1) mod num_req.
  - Next state is ON if code != 0, otherwise GAP.
- Handshake: a request is consumed only by its req_ready pulse. req_valid deasserted before a grant is ignored. No requests are accepted while busy.
- ON: led=1 for exactly on_ticks*div cycles, then OFF; remaining-pulse count decrements on exit.
- OFF: led=0 for off_ticks*div cycles. Next state is ON if the remaining count is > 0, else GAP.
- GAP:
  - led=0 for gap_ticks*div cycles.
  - done=1 in the cycle the FSM returns to IDLE.
  - A new grant is possible in that same IDLE cycle.
- Code 0: grant, then GAP only (LED stays dark), then done.
- Prescaler:
  - Counts 0..div-1 and pulses tick on reaching div-1.
  - Cleared on every state entry, so every duration is exact in clk cycles.
  - The tick counter also clears on state entry; exit occurs on the clock where the tick count reaches the state's target.
- Timing, code c:
  - led rises the cycle after req_ready.
  - busy stays high for c*(on_ticks+off_ticks)*div + gap_ticks*div cycles.
  - done pulses in the cycle the FSM re-enters IDLE (immediately after the last GAP cycle).
- Widths: tick counter sized $clog2(max(on,off,gap)_ticks+1); prescaler sized $clog2(div); pulse counter is code_w bits. Maximum code 2^code_w-1, with no overflow.
- Simultaneous request from the just-served requester and another: the RR pointer gives priority to the other.

Decomposition:
- Shared header/package holds:
  - FSM state encodings (IDLE=0, ON=1, OFF=2, GAP=3)
  - a width helper for counter sizing
  - the div computation and legality check
- One sub-module, blink_tick_prescaler:
  - inputs clk, rst_n, clear
  - output tick
  - parameter div
- Arbiter and FSM stay in led_blink_scheduler.

Test Plan:
All scenarios use clk_freq_hz=1000, tick_hz=100 (div=10), on_ticks=2, off_ticks=2, gap_ticks=3, num_req=4.
- Single request, req 2, code 3 -> req_ready=4'b0100 one cycle; grant_id=2; led high 20 / low 20 cycles x3; then 30 dark cycles; done after 150 busy cycles.
- Requests 0, 1 and 3 valid continuously with codes 1 -> grant order 0, 1, 3, 0, ...; each busy window 70 cycles; done between each grant.
- Code 0 on req 1 -> ready pulse; led never rises; busy 30 cycles; done pulses.
- rst_n low 5 cycles into the second ON pulse -> led=0 the same cycle; busy=0; after release, the pending req 0 is granted first (pointer=0).
- req_valid[3] pulsed for one cycle while busy -> never acknowledged; no ready pulse on req 3.
- Code 15 on req 0 -> exactly 15 rising edges on led; no wrap; busy 630 cycles.
